// File: rtl/wave_pkg.sv
// wave_pkg: shared state encoding, default counter width and length clamp for the toggle sequencer
package wave_pkg;
  localparam int CNT_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, HIGH, LOW, PARK} state_e;
  function automatic int unsigned clamp_len(input int unsigned len);
    return (len == 0) ? 1 : len;
  endfunction
endpackage

// File: rtl/wave_len_counter.sv
// wave_len_counter: loadable down-counter with zero flag, used for phase lengths and burst periods
module wave_len_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;
  assign zero_o = cnt_q == '0;
  // load has priority over decrement; async active-low clear
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (dec_i) cnt_q <= cnt_q - W'(1);
endmodule

// File: rtl/wave_toggle_seq.sv
// wave_toggle_seq: toggle-strobe sequencer shaping a downstream TFF into a high/low rectangular wave.
// Optional WAVE_BURST_COUNT_EN adds cfg_burst/done for a fixed number of periods per start.
module wave_toggle_seq
  import wave_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_low,
  output logic             t_out,
  output logic             level,
  output logic             busy
`ifdef WAVE_BURST_COUNT_EN
  ,
  input  logic [CNT_W-1:0] cfg_burst,
  output logic             done
`endif
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_e state_q, state_d;
  logic t_q, t_d, lvl_q, lvl_nx, pend_q, pend_d;
  logic apply, ld, dec, zero, xfer, burst_end;
  logic [CNT_W-1:0] hi_q, lo_q, phi_q, plo_q, ld_val;
  assign xfer      = cfg_valid & ~pend_q;
  assign lvl_nx    = lvl_q ^ t_q;
  assign pend_d    = xfer | (pend_q & ~apply);
  assign cfg_ready = ~pend_q;
  assign t_out     = t_q;
  assign level     = lvl_q;
  assign busy      = state_q != IDLE;
  wave_len_counter #(.W(CNT_W)) u_len (
    .clk    (clk),
    .reset  (reset),
    .load_i (ld),
    .dec_i  (dec),
    .val_i  (ld_val),
    .zero_o (zero)
  );
  // phase sequencing: each phase entry fires one strobe and loads its length; stop parks q low first
  always_comb begin
    state_d = state_q;
    t_d     = 1'b0;
    ld      = 1'b0;
    dec     = 1'b0;
    apply   = 1'b0;
    ld_val  = hi_q - ONE;
    unique case (state_q)
      IDLE: if (start && !stop) begin
        state_d = HIGH;
        t_d     = 1'b1;
        ld      = 1'b1;
        apply   = pend_q;
        ld_val  = (pend_q ? phi_q : hi_q) - ONE;
      end
      HIGH, LOW: begin
        if (stop) begin
          state_d = lvl_nx ? PARK : IDLE;
          t_d     = lvl_nx;
        end else if (!zero) dec = 1'b1;
        else if (state_q == HIGH) begin
          state_d = LOW;
          t_d     = 1'b1;
          ld      = 1'b1;
          ld_val  = lo_q - ONE;
        end else if (!burst_end) begin
          state_d = HIGH;
          t_d     = 1'b1;
          ld      = 1'b1;
          apply   = pend_q;
          ld_val  = (pend_q ? phi_q : hi_q) - ONE;
        end else state_d = IDLE;
      end
      PARK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state, strobe, TFF shadow and the active/pending length registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      t_q     <= 1'b0;
      lvl_q   <= 1'b0;
      pend_q  <= 1'b0;
      hi_q    <= ONE;
      lo_q    <= ONE;
      phi_q   <= ONE;
      plo_q   <= ONE;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      lvl_q   <= lvl_nx;
      pend_q  <= pend_d;
      if (apply) begin
        hi_q <= phi_q;
        lo_q <= plo_q;
      end
      if (xfer) begin
        phi_q <= CNT_W'(clamp_len(32'(cfg_high)));
        plo_q <= CNT_W'(clamp_len(32'(cfg_low)));
      end
    end
`ifdef WAVE_BURST_COUNT_EN
  logic [CNT_W-1:0] bst_q, pbst_q;
  logic bzero, done_q;
  assign burst_end = (bst_q != '0) && bzero;
  assign done      = done_q;
  wave_len_counter #(.W(CNT_W)) u_burst (
    .clk    (clk),
    .reset  (reset),
    .load_i (ld && (state_q == IDLE || apply)),
    .dec_i  (ld && state_q == LOW && !apply),
    .val_i  ((apply ? pbst_q : bst_q) - ONE),
    .zero_o (bzero)
  );
  // burst length follows the same pending/active path as the phase lengths; done marks natural completion
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bst_q  <= '0;
      pbst_q <= '0;
      done_q <= 1'b0;
    end else begin
      if (apply) bst_q <= pbst_q;
      if (xfer) pbst_q <= cfg_burst;
      done_q <= state_q == LOW && !stop && zero && burst_end;
    end
`else
  assign burst_end = 1'b0;
`endif
endmodule

// File: tb/tb_wave_toggle_seq.sv
// tb_wave_toggle_seq: directed and randomized checks of the toggle sequencer against a period-level model
module tb_wave_toggle_seq;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, stop = 1'b0, cfg_valid = 1'b0;
  logic [7:0] cfg_high = '0, cfg_low = '0;
  logic cfg_ready, t_out, level, busy;
  int errors = 0, checks = 0;
  int cur_h = 1, cur_l = 1, pos = 0, mode = 0;
  logic [7:0] ph = 8'd1, pl = 8'd1, ih = '0, il = '0;
  bit mp = 0, inc = 0, mlvl = 0;
  logic [31:0] tmask;

  always #5 clk = ~clk;

  wave_toggle_seq #(.CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_high  (cfg_high),
    .cfg_low   (cfg_low),
    .t_out     (t_out),
    .level     (level),
    .busy      (busy)
  );

  function automatic logic [7:0] clamp1(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model across the clock edge just passed, then release one-shot inputs.
  task automatic tick();
    bit acc;
    @(negedge clk);
    acc = inc && !mp;
    inc = 0;
    if (mode == 1) begin
      pos++;
      if (pos == cur_h + cur_l) begin
        pos = 0;
        if (mp) begin cur_h = ph; cur_l = pl; mp = 0; end
      end
    end else if (mode == 2) begin
      pos = 0;
      if (mp) begin cur_h = ph; cur_l = pl; mp = 0; end
    end
    if (acc) begin mp = 1; ph = clamp1(ih); pl = clamp1(il); end
    start = 0;
    stop = 0;
    cfg_valid = 0;
  endtask

  task automatic offer(input logic [7:0] h, input logic [7:0] l);
    cfg_valid = 1;
    cfg_high = h;
    cfg_low = l;
    inc = 1;
    ih = h;
    il = l;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_t_out", t_out, 0);
      chk("idle_level", level, 0);
      chk("idle_busy", busy, 0);
      chk("idle_cfg_ready", cfg_ready, !mp);
      mode = 0;
    end
  endtask

  task automatic go();
    start = 1;
    mode = 2;
  endtask

  task automatic run(input int n, input int pct);
    bit et;
    tmask = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      et = (pos == 0) || (pos == cur_h);
      chk("run_t_out", t_out, et);
      chk("run_level", level, mlvl);
      chk("run_busy", busy, 1);
      chk("run_cfg_ready", cfg_ready, !mp);
      if (i < 32) tmask[i] = t_out;
      mlvl ^= et;
      mode = 1;
      if ($urandom_range(99) < pct) offer(8'($urandom_range(6)), 8'($urandom_range(6)));
    end
  endtask

  task automatic do_stop();
    stop = 1;
    mode = 3;
    tick();
    if (mlvl) begin
      chk("park_t_out", t_out, 1);
      chk("park_level", level, 1);
      chk("park_busy", busy, 1);
      chk("park_cfg_ready", cfg_ready, !mp);
      tick();
    end
    chk("stop_t_out", t_out, 0);
    chk("stop_level", level, 0);
    chk("stop_busy", busy, 0);
    chk("stop_cfg_ready", cfg_ready, !mp);
    mlvl = 0;
    mode = 0;
  endtask

  initial begin
    idle(3);
    reset = 1;
    idle(3);
    start = 1;
    stop = 1;
    idle(2);

    offer(3, 2); idle(1); go(); run(12, 0);
    chk("basic_pulses", tmask & 32'hfff, 32'h529);
    do_stop(); idle(2);

    offer(0, 0); idle(1); go(); run(8, 0);
    chk("clamp_pulses", tmask & 32'hff, 32'hff);
    do_stop(); idle(1);

    offer(3, 2); idle(1); go(); run(2, 0);
    offer(1, 4); run(14, 0);
    chk("reconf_pulses", tmask & 32'hffff, 32'h231a);
    do_stop(); idle(1);

    offer(4, 4); idle(1); go(); run(2, 0);
    do_stop(); idle(2);

    offer(4, 4); idle(1); go(); run(6, 0);
    offer(2, 2); run(1, 0);
    #2 reset = 0;
    #1;
    chk("async_t_out", t_out, 0);
    chk("async_level", level, 0);
    chk("async_busy", busy, 0);
    chk("async_cfg_ready", cfg_ready, 1);
    cur_h = 1; cur_l = 1; ph = 8'd1; pl = 8'd1;
    mp = 0; inc = 0; mlvl = 0; mode = 0;
    idle(2);
    reset = 1;
    idle(3);
    go(); run(6, 0);
    do_stop(); idle(1);

    for (int r = 0; r < 8; r++) begin
      offer(8'($urandom_range(6)), 8'($urandom_range(6)));
      idle(1);
      go();
      run($urandom_range(30, 5), 20);
      do_stop();
      idle(2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
